// File: rtl/vproc_cfg_if.sv
// Operation issue and scalar result handshake between the vector issue stage
// and the configuration/CSR unit.
interface vproc_cfg_if;
    logic        op_valid_i;
    logic        op_ready_o;
    logic [3:0]  csr_op_i;
    logic [2:0]  vsew_i;
    logic [2:0]  lmul_i;
    logic [1:0]  agnostic_i;
    logic        vlmax_i;
    logic        keep_vl_i;
    logic [31:0] rs1_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] res_data_o;

    modport slave (
        input  op_valid_i, csr_op_i, vsew_i, lmul_i, agnostic_i,
               vlmax_i, keep_vl_i, rs1_i, res_ready_i,
        output op_ready_o, res_valid_o, res_data_o
    );

    modport master (
        output op_valid_i, csr_op_i, vsew_i, lmul_i, agnostic_i,
               vlmax_i, keep_vl_i, rs1_i, res_ready_i,
        input  op_ready_o, res_valid_o, res_data_o
    );
endinterface

// File: rtl/vproc_cfg_unit.sv
// Vector configuration/CSR unit: owns vtype, vl, vstart, vxrm, vxsat and executes
// vsetvl-family and vector CSR operations, stalling vsetvl until the pipeline drains.
module vproc_cfg_unit #(
    parameter int unsigned VREG_W   = 128,
    parameter bit          SEW64_EN = 1'b0,
    localparam int unsigned VL_W    = $clog2(VREG_W) + 1
) (
    input  logic            clk_i,
    input  logic            sync_rst_i,
    vproc_cfg_if.slave      bus,
    input  logic            drain_i,
    input  logic            vxsat_set_i,
    output logic [2:0]      vsew_o,
    output logic [2:0]      lmul_o,
    output logic [VL_W-1:0] vl_o,
    output logic            vill_o,
    output logic [VL_W-1:0] vstart_o,
    output logic [1:0]      vxrm_o,
    output logic            vxsat_o
);
    localparam logic [3:0] OP_VSETVL = 4'd0,  OP_VTYPE_RD = 4'd1,  OP_VL_RD = 4'd2,
                           OP_VLENB_RD = 4'd3, OP_VSTART_WR = 4'd4, OP_VSTART_SET = 4'd5,
                           OP_VSTART_CLR = 4'd6, OP_VXRM_WR = 4'd7,  OP_VXRM_SET = 4'd8,
                           OP_VXRM_CLR = 4'd9, OP_VXSAT_WR = 4'd10, OP_VXSAT_SET = 4'd11,
                           OP_VXSAT_CLR = 4'd12, OP_VCSR_WR = 4'd13, OP_VCSR_SET = 4'd14,
                           OP_VCSR_CLR = 4'd15;
    localparam logic [2:0] LMUL_1 = 3'd0, LMUL_INVALID = 3'd4;
    localparam logic [1:0] VXRM_RNU = 2'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_DRAIN, ST_RESULT} state_e;

    state_e r_state, w_state_nxt;
    logic   w_accept, w_exec;
    logic   r_op_ready, r_res_valid;

    logic [3:0]      r_op;
    logic [2:0]      r_vsew_in, r_lmul_in;
    logic [1:0]      r_agn_in;
    logic            r_vlmax_in, r_keep_in;
    logic [31:0]     r_rs1;

    logic [2:0]      r_vsew, r_lmul;
    logic [1:0]      r_agn, r_vxrm;
    logic [VL_W-1:0] r_vl, r_vstart;
    logic            r_vill, r_vxsat;
    logic [31:0]     r_res_data;

    logic [3:0]      w_op;
    logic [2:0]      w_vsew, w_lmul;
    logic [1:0]      w_agn;
    logic            w_vlmax_sel, w_keep;
    logic [31:0]     w_rs1;
    logic            w_frac, w_vill;
    logic [1:0]      w_shl;
    logic [3:0]      w_shr;
    logic [31:0]     w_vlmax, w_result;
    logic [VL_W-1:0] w_vl_new, w_vs_new;
    logic [1:0]      w_kind, w_xrm_new;
    logic            w_xsat_new;
    logic [2:0]      w_vcsr_new;

    // Operand source: live bus when accepting in IDLE, captured copy while stalled
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_op = bus.csr_op_i;   w_vsew = bus.vsew_i;       w_lmul = bus.lmul_i;
            w_agn = bus.agnostic_i; w_vlmax_sel = bus.vlmax_i; w_keep = bus.keep_vl_i;
            w_rs1 = bus.rs1_i;
        end else begin
            w_op = r_op;   w_vsew = r_vsew_in;       w_lmul = r_lmul_in;
            w_agn = r_agn_in; w_vlmax_sel = r_vlmax_in; w_keep = r_keep_in;
            w_rs1 = r_rs1;
        end
    end

    // VLMAX = VREG_W * LMUL / SEW in bits, fractional LMUL folded into the right shift
    always_comb begin
        w_frac  = w_lmul[2] && (w_lmul[1:0] != 2'd0);
        w_shl   = w_frac ? 2'd0 : w_lmul[1:0];
        w_shr   = 4'd3 + {2'b00, w_vsew[1:0]} + (w_frac ? (4'd8 - {1'b0, w_lmul}) : 4'd0);
        w_vlmax = (32'(VREG_W) << w_shl) >> w_shr;
        w_vill  = w_vsew[2] || ((w_vsew[1:0] == 2'd3) && !SEW64_EN)
                  || (w_lmul == LMUL_INVALID) || (w_vlmax == 32'd0);
        if (w_vlmax_sel)
            w_vl_new = VL_W'(w_vlmax);
        else if (w_keep)
            w_vl_new = (32'(r_vl) < w_vlmax) ? r_vl : VL_W'(w_vlmax);
        else
            w_vl_new = (w_rs1 < w_vlmax) ? VL_W'(w_rs1) : VL_W'(w_vlmax);
    end

    // CSR read-modify-write: 0 = write, 1 = set, 2 = clear
    always_comb begin
        w_kind = 2'd0;
        case (w_op)
            OP_VSTART_SET, OP_VXRM_SET, OP_VXSAT_SET, OP_VCSR_SET: w_kind = 2'd1;
            OP_VSTART_CLR, OP_VXRM_CLR, OP_VXSAT_CLR, OP_VCSR_CLR: w_kind = 2'd2;
            default: w_kind = 2'd0;
        endcase
        case (w_kind)
            2'd1: begin
                w_vs_new   = r_vstart | w_rs1[VL_W-1:0];
                w_xrm_new  = r_vxrm | w_rs1[1:0];
                w_xsat_new = r_vxsat | w_rs1[0];
                w_vcsr_new = {r_vxrm, r_vxsat} | w_rs1[2:0];
            end
            2'd2: begin
                w_vs_new   = r_vstart & ~w_rs1[VL_W-1:0];
                w_xrm_new  = r_vxrm & ~w_rs1[1:0];
                w_xsat_new = r_vxsat & ~w_rs1[0];
                w_vcsr_new = {r_vxrm, r_vxsat} & ~w_rs1[2:0];
            end
            default: begin
                w_vs_new   = w_rs1[VL_W-1:0];
                w_xrm_new  = w_rs1[1:0];
                w_xsat_new = w_rs1[0];
                w_vcsr_new = w_rs1[2:0];
            end
        endcase
    end

    always_comb begin
        w_result = 32'd0;
        case (w_op)
            OP_VSETVL:   w_result = w_vill ? 32'd0 : 32'(w_vl_new);
            OP_VTYPE_RD: w_result = {r_vill, 23'd0, r_agn, r_vsew, r_lmul};
            OP_VL_RD:    w_result = 32'(r_vl);
            OP_VLENB_RD: w_result = 32'(VREG_W / 8);
            OP_VSTART_WR, OP_VSTART_SET, OP_VSTART_CLR: w_result = 32'(r_vstart);
            OP_VXRM_WR, OP_VXRM_SET, OP_VXRM_CLR:       w_result = 32'(r_vxrm);
            OP_VXSAT_WR, OP_VXSAT_SET, OP_VXSAT_CLR:    w_result = 32'(r_vxsat);
            default:     w_result = 32'({r_vxrm, r_vxsat});
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_exec      = 1'b0;
        case (r_state)
            ST_IDLE: if (bus.op_valid_i) begin
                w_accept = 1'b1;
                if (bus.csr_op_i == OP_VSETVL && !drain_i) begin
                    w_state_nxt = ST_WAIT_DRAIN;
                end else begin
                    w_exec      = 1'b1;
                    w_state_nxt = ST_RESULT;
                end
            end
            ST_WAIT_DRAIN: if (drain_i) begin
                w_exec      = 1'b1;
                w_state_nxt = ST_RESULT;
            end
            ST_RESULT: if (bus.res_ready_i) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_state     <= ST_IDLE;
            r_op_ready  <= 1'b1;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op_ready  <= (w_state_nxt == ST_IDLE);
            r_res_valid <= (w_state_nxt == ST_RESULT);
        end
    end

    // Architectural state; an executing vxsat/vcsr write overrides the same-cycle set
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_op <= OP_VSETVL; r_vsew_in <= 3'd0; r_lmul_in <= LMUL_1; r_agn_in <= 2'd0;
            r_vlmax_in <= 1'b0; r_keep_in <= 1'b0; r_rs1 <= 32'd0;
            r_vill <= 1'b1; r_vl <= '0; r_vsew <= 3'd0; r_lmul <= LMUL_1; r_agn <= 2'd0;
            r_vstart <= '0; r_vxrm <= VXRM_RNU; r_vxsat <= 1'b0; r_res_data <= 32'd0;
        end else begin
            r_vxsat <= r_vxsat | vxsat_set_i;
            if (w_accept) begin
                r_op <= w_op; r_vsew_in <= w_vsew; r_lmul_in <= w_lmul; r_agn_in <= w_agn;
                r_vlmax_in <= w_vlmax_sel; r_keep_in <= w_keep; r_rs1 <= w_rs1;
            end
            if (w_exec) begin
                r_res_data <= w_result;
                case (w_op)
                    OP_VSETVL: begin
                        r_vill   <= w_vill;
                        r_vl     <= w_vill ? '0 : w_vl_new;
                        r_vsew   <= w_vill ? 3'd0 : w_vsew;
                        r_lmul   <= w_vill ? LMUL_1 : w_lmul;
                        r_agn    <= w_vill ? 2'd0 : w_agn;
                        r_vstart <= '0;
                    end
                    OP_VSTART_WR, OP_VSTART_SET, OP_VSTART_CLR: r_vstart <= w_vs_new;
                    OP_VXRM_WR, OP_VXRM_SET, OP_VXRM_CLR:       r_vxrm   <= w_xrm_new;
                    OP_VXSAT_WR, OP_VXSAT_SET, OP_VXSAT_CLR:    r_vxsat  <= w_xsat_new;
                    OP_VCSR_WR, OP_VCSR_SET, OP_VCSR_CLR:       {r_vxrm, r_vxsat} <= w_vcsr_new;
                    default: ;
                endcase
            end
        end
    end

    assign bus.op_ready_o  = r_op_ready;
    assign bus.res_valid_o = r_res_valid;
    assign bus.res_data_o  = r_res_data;
    assign vsew_o   = r_vsew;
    assign lmul_o   = r_lmul;
    assign vl_o     = r_vl;
    assign vill_o   = r_vill;
    assign vstart_o = r_vstart;
    assign vxrm_o   = r_vxrm;
    assign vxsat_o  = r_vxsat;
endmodule

// File: doc/vproc_cfg_unit.md
Name: vproc_cfg_unit

Overview:
- Configuration/CSR execution unit of the vector processor.
- Owns architectural vector state: vtype, vl, vstart, vxrm, vxsat.
- Executes vsetvl-family and vector CSR operations (cfg_csr_op encoding) and returns a scalar result through a valid/ready handshake.
- Generalises the fixed 8/16/32-bit SEW configuration with a parametrised register width and optional 64-bit SEW. A vsetvl is stalled until the downstream pipeline has drained.

Parameters:
- VREG_W, 128, vector register width in bits (power of two, >=64).
- SEW64_EN, 0, 1 = SEW 64 legal (vsew_i=3), 0 = vsew_i=3 sets vill.
- VL_W, $clog2(VREG_W)+1, width of vl/vstart (derived, not overridden).

Ports:
- clk_i  in  1  clock
- sync_rst_i  in  1  synchronous active-high reset
- op_valid_i  in  1  operation valid
- op_ready_o  out  1  unit accepts operation
- csr_op_i  in  4  cfg_csr_op encoding
- vsew_i  in  3  0=8,1=16,2=32,3=64; 4..7 illegal
- lmul_i  in  3  cfg_lmul encoding
- agnostic_i  in  2  {vma,vta}
- vlmax_i  in  1  vsetvl: set vl=VLMAX
- keep_vl_i  in  1  vsetvl: keep vl
- rs1_i  in  32  AVL or CSR operand
- drain_i  in  1  downstream pipeline empty
- vxsat_set_i  in  1  saturation event from ALU/MUL
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumed
- res_data_o  out  32  result value
- vsew_o  out  3  current SEW
- lmul_o  out  3  current LMUL
- vl_o  out  VL_W  current vl
- vill_o  out  1  vtype illegal
- vstart_o  out  VL_W  current vstart
- vxrm_o  out  2  current rounding mode
- vxsat_o  out  1  current saturation flag

Behaviour:
- Reset values (next edge with sync_rst_i=1):
  - vill_o=1, vl_o=0, vsew_o=0, lmul_o=LMUL_1, agnostic=0, vstart_o=0, vxrm_o=RNU, vxsat_o=0.
  - FSM=IDLE, res_valid_o=0, res_data_o=0.
  - Reset mid-operation abandons the operation; no partial state update.
- FSM states: IDLE, WAIT_DRAIN, RESULT.
  - op_ready_o=1 only in IDLE.
  - Handshake op_valid_i&op_ready_o accepts and registers all op inputs.
- Accepted CFG_VSETVL with drain_i=0: go to WAIT_DRAIN. Execute on the first cycle drain_i=1, then go to RESULT.
- Accepted CFG_VSETVL with drain_i=1, or any other op: execute in the accept cycle, then go to RESULT.
- Execute updates state at the clock edge. res_valid_o=1 from the next cycle; 1-cycle latency without stall.
- RESULT holds res_valid_o/res_data_o stable until res_ready_i=1, then returns to IDLE. No back-to-back acceptance; minimum 2 cycles per op.
- VLMAX = (VREG_W/8) * LMUL / SEW_bytes, computed with shifts. Fractional LMUL divides.
- vill conditions:
  - vsew_i>3, or vsew_i=3 with SEW64_EN=0.
  - lmul_i=LMUL_INVALID.
  - VLMAX=0.
- vsetvl, vill case: vill=1, vl=0, vsew/lmul/agnostic cleared, result 0.
- vsetvl, valid case:
  - vlmax_i: vl=VLMAX.
  - keep_vl_i: vl=min(vl,VLMAX).
  - otherwise: vl=min(rs1_i,VLMAX), comparing the full 32 bits.
  - Result = new vl, zero-extended. vstart is cleared.
- Read ops, result only:
  - VTYPE_READ = {vill,23'b0,vma,vta,vsew[2:0],lmul[2:0]}; vill=1 returns 32'h8000_0000.
  - VL_READ = vl.
  - VLENB_READ = VREG_W/8.
- WRITE/SET/CLEAR ops: new = rs1, old|rs1, old&~rs1 respectively.
  - Result = old value, zero-extended.
  - vstart truncated to VL_W bits.
  - vcsr = {vxrm,vxsat}, bits above 2 ignored.
- vxsat_set_i ORs into vxsat every cycle, in every state.
  - An executing VXSAT/VCSR op in the same cycle takes priority; that cycle's set is dropped.
- Outputs are registered state; no combinational path from inputs to state outputs.

Test Plan:
- VREG_W=128, vsetvl rs1=20, vsew=2 (e32), lmul=LMUL_2, drain_i=1:
  - res_valid_o 1 cycle after accept, res_data_o=8, vl_o=8, vill_o=0.
  - VTYPE_READ then returns 32'h0000_0011.
- SEW64_EN=0, vsewi=3: vill_o=1, vl_o=0, VTYPE_READ=32'h8000_0000. Same op with SEW64_EN=1, LMUL_1, vlmax_i=1: vl_o=2.
- Fractional LMUL:
  - e32/LMUL_F8: VLMAX=0, vill_o=1.
  - e8/LMUL_F2 with rs1=100: vl_o=8.
  - keep_vl_i from vl=8 to e16/LMUL_1: vl_o=8; then to e32/LMUL_F2: vl_o=2.
- Drain stall: accept vsetvl with drain_i=0 for 3 cycles.
  - op_ready_o=0 and vl_o unchanged throughout.
  - vl_o updates on the edge where drain_i=1; res_valid_o the following cycle.
- CSR ops:
  - VXRM_WRITE rs1=2 returns 0, vxrm_o=2.
  - VCSR_SET rs1=1 returns 4, vxsat_o=1.
  - VXSAT_CLEAR with simultaneous vxsat_set_i=1 gives vxsat_o=0; the next set gives 1.
- Backpressure/reset:
  - res_ready_i=0 for 4 cycles: res_data_o stable, op_ready_o=0.
  - sync_rst_i asserted in WAIT_DRAIN: next cycle IDLE, all outputs at reset values, res_valid_o never asserted.
